sprite_draw_arbiter: RTL and testbench

Shares the single 4x4 tile drawer between several requesters, such as the player sprite, moving platforms and the level redraw logic. It grants one request at a time in round-robin order and translates each request into one or two drawer jobs. For a MOVE request it erases the old tile with background, then draws the character tile at the new location. It drives the drawer's `drawChar`/`drawBG`/`data_x`/`data_y` inputs and consumes its `doneDraw`.

---
 rtl/draw_arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 28 ++
 rtl/sprite_draw_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sprite_draw_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_arb_pkg.sv
// Shared encodings for the sprite draw arbiter: requester op codes and FSM states.
package draw_arb_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_BG   = 2'b01;
  localparam logic [1:0] OP_CHAR = 2'b10;
  localparam logic [1:0] OP_MOVE = 2'b11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DRAW_BG   = 3'd1;
  localparam logic [2:0] ST_GAP       = 3'd2;
  localparam logic [2:0] ST_DRAW_CHAR = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    DRAW_BG   = ST_DRAW_BG,
    GAP       = ST_GAP,
    DRAW_CHAR = ST_DRAW_CHAR,
    ACK       = ST_ACK
  } arb_state_e;

  function automatic logic op_needs_bg(input logic [1:0] o);
    return (o == OP_BG) || (o == OP_MOVE);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first asserted request after 'last', with wrap.
module rr_pick
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      grant_idx
);

  logic [IW-1:0] cand_s;

  // Walk candidates from farthest to nearest so the nearest hit after 'last' wins.
  always_comb begin
    valid     = 1'b0;
    grant_idx = '0;
    cand_s    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s    = IW'((int'(last) + k) % NUM_REQ);
      valid     = valid | req[cand_s];
      grant_idx = req[cand_s] ? cand_s : grant_idx;
    end
  end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Shares one 4x4 tile drawer among NUM_REQ requesters; MOVE becomes an erase job
// followed, after a one-cycle gap, by a character job at the new location.
module sprite_draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XW      = 9,
  parameter int YW      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [2*NUM_REQ-1:0]  op,
  input  logic [XW*NUM_REQ-1:0] old_x,
  input  logic [YW*NUM_REQ-1:0] old_y,
  input  logic [XW*NUM_REQ-1:0] new_x,
  input  logic [YW*NUM_REQ-1:0] new_y,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  busy,
  output logic                  drawBG,
  output logic                  drawChar,
  output logic [XW-1:0]         data_x,
  output logic [YW-1:0]         data_y,
  input  logic                  doneDraw
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q;
  logic [IW-1:0]       last_q;
  logic [IW-1:0]       grant_q;
  logic [1:0]          op_q;
  logic [XW-1:0]       new_x_q;
  logic [YW-1:0]       new_y_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                busy_q;
  logic                bg_q;
  logic                char_q;
  logic [XW-1:0]       data_x_q;
  logic [YW-1:0]       data_y_q;

  logic                pick_valid_s;
  logic [IW-1:0]       pick_idx_s;
  logic [1:0]          sel_op_s;
  logic [XW-1:0]       sel_old_x_s;
  logic [YW-1:0]       sel_old_y_s;
  logic [XW-1:0]       sel_new_x_s;
  logic [YW-1:0]       sel_new_y_s;
  logic [NUM_REQ-1:0]  ack_hot_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req       (req),
    .last      (last_q),
    .valid     (pick_valid_s),
    .grant_idx (pick_idx_s)
  );

  // Operand mux for the current winner and one-hot decode of the held grant.
  always_comb begin
    sel_op_s    = OP_NOP;
    sel_old_x_s = '0;
    sel_old_y_s = '0;
    sel_new_x_s = '0;
    sel_new_y_s = '0;
    ack_hot_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_op_s     = (pick_idx_s == IW'(i)) ? op[2*i +: 2]      : sel_op_s;
      sel_old_x_s  = (pick_idx_s == IW'(i)) ? old_x[XW*i +: XW] : sel_old_x_s;
      sel_old_y_s  = (pick_idx_s == IW'(i)) ? old_y[YW*i +: YW] : sel_old_y_s;
      sel_new_x_s  = (pick_idx_s == IW'(i)) ? new_x[XW*i +: XW] : sel_new_x_s;
      sel_new_y_s  = (pick_idx_s == IW'(i)) ? new_y[YW*i +: YW] : sel_new_y_s;
      ack_hot_s[i] = (grant_q == IW'(i));
    end
  end

  // Arbitration FSM with capture and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= IW'(NUM_REQ - 1);
      grant_q  <= '0;
      op_q     <= OP_NOP;
      new_x_q  <= '0;
      new_y_q  <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      bg_q     <= 1'b0;
      char_q   <= 1'b0;
      data_x_q <= '0;
      data_y_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (pick_valid_s) begin
            grant_q <= pick_idx_s;
            op_q    <= sel_op_s;
            new_x_q <= sel_new_x_s;
            new_y_q <= sel_new_y_s;
            busy_q  <= 1'b1;
            if (op_needs_bg(sel_op_s)) begin
              state_q  <= DRAW_BG;
              bg_q     <= 1'b1;
              data_x_q <= sel_old_x_s;
              data_y_q <= sel_old_y_s;
            end else if (sel_op_s == OP_CHAR) begin
              state_q  <= DRAW_CHAR;
              char_q   <= 1'b1;
              data_x_q <= sel_new_x_s;
              data_y_q <= sel_new_y_s;
            end else begin
              state_q <= ACK;
            end
          end
        end
        DRAW_BG: begin
          if (doneDraw) begin
            bg_q    <= 1'b0;
            state_q <= GAP;
          end
        end
        // One idle cycle lets the drawer leave DONE before the next job.
        GAP: begin
          if (op_q == OP_MOVE) begin
            data_x_q <= new_x_q;
            data_y_q <= new_y_q;
            char_q   <= 1'b1;
            state_q  <= DRAW_CHAR;
          end else begin
            state_q <= ACK;
          end
        end
        DRAW_CHAR: begin
          if (doneDraw) begin
            char_q  <= 1'b0;
            state_q <= ACK;
          end
        end
        ACK: begin
          ack_q   <= ack_hot_s;
          last_q  <= grant_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          bg_q    <= 1'b0;
          char_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign drawBG   = bg_q;
  assign drawChar = char_q;
  assign data_x   = data_x_q;
  assign data_y   = data_y_q;

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Randomized bench for sprite_draw_arbiter with a transaction-level reference model
// and a behavioural tile-drawer that answers each job after a chosen latency.
module tb_sprite_draw_arbiter;

  localparam int N  = 3;
  localparam int XW = 9;
  localparam int YW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [2*N-1:0]    op;
  logic [XW*N-1:0]   old_x, new_x;
  logic [YW*N-1:0]   old_y, new_y;
  logic [N-1:0]      ack;
  logic              busy, drawBG, drawChar, doneDraw;
  logic [XW-1:0]     data_x;
  logic [YW-1:0]     data_y;

  int total = 0;
  int bad   = 0;

  // Reference model state: pending requests, their operands, round-robin pointer.
  int         last_m;
  bit         m_pend [N];
  logic [1:0] m_op   [N];
  int         m_ox [N], m_oy [N], m_nx [N], m_ny [N];

  sprite_draw_arbiter #(.NUM_REQ(N), .XW(XW), .YW(YW)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .op       (op),
    .old_x    (old_x),
    .old_y    (old_y),
    .new_x    (new_x),
    .new_y    (new_y),
    .ack      (ack),
    .busy     (busy),
    .drawBG   (drawBG),
    .drawChar (drawChar),
    .data_x   (data_x),
    .data_y   (data_y),
    .doneDraw (doneDraw)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic post_req(input int i, input logic [1:0] o, input int ox, input int oy,
                          input int nx, input int ny);
    m_pend[i] = 1'b1;
    m_op[i]   = o;
    m_ox[i] = ox; m_oy[i] = oy; m_nx[i] = nx; m_ny[i] = ny;
    req[i]              = 1'b1;
    op[2*i +: 2]        = o;
    old_x[XW*i +: XW]   = XW'(ox);
    old_y[YW*i +: YW]   = YW'(oy);
    new_x[XW*i +: XW]   = XW'(nx);
    new_y[YW*i +: YW]   = YW'(ny);
  endtask

  function automatic int model_winner();
    for (int k = 1; k <= N; k++) begin
      if (m_pend[(last_m + k) % N]) return (last_m + k) % N;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; req = '0; op = '0; doneDraw = 1'b0;
    old_x = '0; old_y = '0; new_x = '0; new_y = '0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    last_m = N - 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One grant from the model's winner to its ack, acting as the drawer meanwhile.
  // Called at a negedge while the DUT is idle with the request(s) already posted.
  task automatic run_round(input int lat);
    int w, n_exp, n_jobs, k, kd, ka, cnt, exp_ack_k;
    logic [1:0] exp_t [2];
    int exp_x [2];
    int exp_y [2];
    logic prev;
    w = model_winner();
    if (w < 0) return;
    n_exp = 0;
    if (m_op[w] == 2'b01 || m_op[w] == 2'b11) begin
      exp_t[n_exp] = 2'b01; exp_x[n_exp] = m_ox[w]; exp_y[n_exp] = m_oy[w]; n_exp++;
    end
    if (m_op[w] == 2'b10 || m_op[w] == 2'b11) begin
      exp_t[n_exp] = 2'b10; exp_x[n_exp] = m_nx[w]; exp_y[n_exp] = m_ny[w]; n_exp++;
    end
    n_jobs = 0; k = 0; kd = 0; ka = -1; cnt = 0; prev = 1'b0;
    while (ka < 0 && k < 300) begin
      @(posedge clock);
      @(negedge clock);
      k++;
      if (k == 1) begin
        check_val("ack_clear", ack, 0);
        check_val("busy_grant", busy, 1);
      end
      check_val("flag_excl", drawBG & drawChar, 0);
      if (drawBG | drawChar) begin
        if (!prev) begin
          check_val("job_start", k, (n_jobs == 0) ? 1 : kd + 2);
          n_jobs++;
          cnt = lat;
        end
        if (n_jobs <= n_exp) begin
          check_val("job_type", {drawChar, drawBG}, exp_t[n_jobs-1]);
          check_val("job_x", data_x, exp_x[n_jobs-1]);
          check_val("job_y", data_y, exp_y[n_jobs-1]);
        end else begin
          check_val("extra_job", n_jobs, n_exp);
        end
        if (!doneDraw) begin
          if (cnt == 0) begin
            doneDraw = 1'b1;
            kd = k;
          end else begin
            cnt--;
          end
        end
      end else begin
        doneDraw = 1'b0;
      end
      prev = drawBG | drawChar;
      if (ack != '0) ka = k;
    end
    // Erase-only jobs spend an extra cycle in the gap before acknowledging.
    if (n_exp == 0) exp_ack_k = 2;
    else if (exp_t[n_exp-1] == 2'b01) exp_ack_k = kd + 3;
    else exp_ack_k = kd + 2;
    check_val("ack_lat", ka, exp_ack_k);
    check_val("ack_who", ack, 1 << w);
    check_val("n_jobs", n_jobs, n_exp);
    check_val("busy_at_ack", busy, 0);
    m_pend[w] = 1'b0;
    req[w]    = 1'b0;
    last_m    = w;
  endtask

  initial begin
    int k;
    do_reset();

    for (int c = 0; c < 10; c++) begin
      check_val("idle_outs", {ack, busy, drawBG, drawChar, data_x, data_y}, 0);
      @(posedge clock);
      @(negedge clock);
    end

    post_req(0, 2'b01, 40, 16, 0, 0);
    run_round(66);

    post_req(1, 2'b11, 40, 16, 44, 16);
    run_round(3);

    for (int r = 0; r < 4; r++) begin
      if (!m_pend[0]) post_req(0, 2'b10, 8 * r, 4, 12 * r, 20);
      if (!m_pend[1]) post_req(1, 2'b10, 100, 8 * r, 200, 30 + r);
      run_round(r % 3);
    end

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_pend[i] && $urandom_range(0, 1) == 1)
          post_req(i, 2'($urandom_range(0, 3)), $urandom_range(0, 511), $urandom_range(0, 255),
                   $urandom_range(0, 511), $urandom_range(0, 255));
      end
      if (!any_pend())
        post_req($urandom_range(0, N - 1), 2'($urandom_range(0, 3)), $urandom_range(0, 511),
                 $urandom_range(0, 255), $urandom_range(0, 511), $urandom_range(0, 255));
      run_round($urandom_range(0, 5));
    end
    while (any_pend()) run_round(1);

    post_req(1, 2'b00, 5, 6, 7, 8);
    run_round(0);

    post_req(1, 2'b10, 100, 50, 200, 60);
    k = 0;
    while (!drawChar && k < 20) begin
      @(posedge clock);
      @(negedge clock);
      k++;
    end
    check_val("char_started", drawChar, 1);
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_val("rst_outs", {ack, busy, drawBG, drawChar, data_x, data_y}, 0);
    reset = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    last_m = N - 1;
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      check_val("rst_no_ack", {ack, busy}, 0);
    end
    post_req(1, 2'b00, 0, 0, 0, 0);
    post_req(0, 2'b00, 0, 0, 0, 0);
    run_round(0);
    run_round(0);

    @(posedge clock);
    @(negedge clock);
    check_val("final_ack_clear", ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
